// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 keyboard receiver with E0/F0 prefix merge and event FIFO (option: PS2_PARITY_CHECK_EN)
module ps2_receiver #(
  parameter int FILTER_LEN = 2,
  parameter int TIMEOUT    = 7100,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_clk,
  input  logic       key_data,
  input  logic       rd,
  output logic [9:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic           clk_s1, clk_s2, data_s1, data_s2;
  logic           flt, flt_d;
  logic [FCW-1:0] flt_cnt;
  logic           strobe;

  state_t         state, state_n;
  logic [3:0]     bit_cnt, bit_cnt_n;
  logic [9:0]     shreg, shreg_n;
  logic [TW-1:0]  idle_cnt, idle_n;
  logic           ext, ext_n, brk, brk_n;
  logic           push, err_c, frame_ok;

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, pop, wr_en;

  // Synchronize both pins and debounce the clock; the filtered clock idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      flt     <= 1'b1;
      flt_d   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1  <= key_clk;
      clk_s2  <= clk_s1;
      data_s1 <= key_data;
      data_s2 <= data_s1;
      flt_d   <= flt;
      if (clk_s2 != flt) begin
        if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
          flt     <= clk_s2;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign strobe = flt_d & ~flt;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = shreg[9] & (^shreg[8:0]);
`else
  // Parity bit is captured but has no influence on acceptance.
  assign frame_ok = shreg[9] & (shreg[8] | 1'b1);
`endif

  // Receiver state, shift register, idle timer and prefix flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      idle_cnt  <= idle_n;
      ext       <= ext_n;
      brk       <= brk_n;
      frame_err <= err_c;
    end
  end

  // Frame reception, validation and E0/F0 prefix merging.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    idle_n    = idle_cnt;
    ext_n     = ext;
    brk_n     = brk;
    push      = 1'b0;
    err_c     = 1'b0;
    case (state)
      IDLE: begin
        idle_n = '0;
        if (strobe && !data_s2) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        if (strobe) begin
          shreg_n = {data_s2, shreg[9:1]};
          idle_n  = '0;
          if (bit_cnt == 4'd9) state_n = CHECK;
          else bit_cnt_n = bit_cnt + 4'd1;
        end else if (idle_cnt == TW'(TIMEOUT)) begin
          state_n = IDLE;
          err_c   = 1'b1;
          ext_n   = 1'b0;
          brk_n   = 1'b0;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (!frame_ok) begin
          err_c = 1'b1;
          ext_n = 1'b0;
          brk_n = 1'b0;
        end else if (shreg[7:0] == 8'hE0) begin
          ext_n = 1'b1;
        end else if (shreg[7:0] == 8'hF0) begin
          brk_n = 1'b1;
        end else begin
          push  = 1'b1;
          ext_n = 1'b0;
          brk_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign valid = (count != '0);
  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop   = rd & valid;
  assign wr_en = push & (~full | pop);
  assign data  = valid ? mem[rd_ptr] : 10'd0;

  // Event storage; a push into a full FIFO survives only if a pop frees a slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ext, brk, shreg[7:0]};
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - self-checking bench for ps2_receiver
module tb_ps2_receiver;
  localparam int FILTER_LEN = 2;
  localparam int TIMEOUT    = 7100;
  localparam int FIFO_AW    = 3;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int PH         = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_clk = 1'b1;
  logic       key_data = 1'b1;
  logic       rd = 1'b0;
  logic [9:0] data;
  logic       valid, frame_err, overflow;

  int checks = 0;
  int passed = 0;
  int err_seen = 0;
  int exp_err = 0;
  bit armed = 1'b0;

  logic [9:0] model_q[$];
  bit         model_ovf = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .reset(reset), .key_clk(key_clk), .key_data(key_data), .rd(rd),
    .data(data), .valid(valid), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Keyboard semantics: prefixes accumulate, any other code emits one event.
  task automatic model_event(input logic [7:0] code, input bit par_ok, input bit popping);
    bit ok;
`ifdef PS2_PARITY_CHECK_EN
    ok = par_ok;
`else
    ok = 1'b1;
`endif
    if (popping && model_q.size() != 0) void'(model_q.pop_front());
    if (!ok) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'hF0) m_brk = 1'b1;
    else begin
      if (model_q.size() < DEPTH) model_q.push_back({m_ext, m_brk, code});
      else model_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("valid", 16'(valid), 16'(model_q.size() != 0));
      chk("overflow", 16'(overflow), 16'(model_ovf));
      if (valid && model_q.size() != 0) chk("data", 16'(data), 16'(model_q[0]));
      if (frame_err) err_seen++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_q.delete();
    model_ovf = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Events become visible FILTER_LEN+4 edges after the stop-bit fall is first sampled.
  task automatic send_frame(input logic [7:0] code, input bit par_ok, input int nbits,
                            input int glitch_at, input bit rd_at_push);
    logic [10:0] b;
    b = {1'b1, (par_ok ? ~^code : ^code), code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      key_data = b[i];
      repeat (2) @(negedge clk);
      key_clk = 1'b0;
      if (i == 10) begin
        repeat (FILTER_LEN + 3) @(posedge clk);
        if (rd_at_push) begin
          @(negedge clk);
          rd = 1'b1;
        end
        @(posedge clk);
        model_event(code, par_ok, rd_at_push);
        @(negedge clk);
        rd = 1'b0;
        repeat (PH - 1) @(negedge clk);
      end else begin
        repeat (PH) @(negedge clk);
      end
      key_clk = 1'b1;
      repeat (PH) @(negedge clk);
      if (glitch_at == i) begin
        key_clk = 1'b0;
        @(negedge clk);
        key_clk = 1'b1;
        repeat (PH) @(negedge clk);
      end
    end
    key_data = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] code);
    send_frame(code, 1'b1, 11, -1, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd = 1'b1;
    @(posedge clk);
    if (model_q.size() != 0) void'(model_q.pop_front());
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    do_reset();
    armed = 1'b1;
    @(negedge clk);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_data", 16'(data), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    chk("rst_ferr", 16'(frame_err), 16'h0);

    send(8'h14);
    chk("lit_14", 16'(data), 16'h014);
    chk("lit_14_valid", 16'(valid), 16'h1);
    pop_one();
    @(negedge clk);
    chk("lit_pop_empty", 16'(valid), 16'h0);

    send(8'hF0);
    send(8'h14);
    chk("lit_114", 16'(data), 16'h114);
    pop_one();
    @(negedge clk);
    chk("lit_one_event", 16'(valid), 16'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("lit_375", 16'(data), 16'h375);
    pop_one();

    send_frame(8'h1C, 1'b0, 11, -1, 1'b0);
    repeat (2) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    chk("lit_par_err", 16'(err_seen), 16'd1);
    chk("lit_par_empty", 16'(valid), 16'h0);
`else
    chk("lit_par_ign", 16'(data), 16'h01C);
    chk("lit_par_noerr", 16'(err_seen), 16'd0);
    pop_one();
`endif

    send(8'hE0);
    send_frame(8'h33, 1'b1, 5, -1, 1'b0);
    repeat (TIMEOUT + 30) @(negedge clk);
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    chk("timeout_err", 16'(err_seen), 16'(exp_err));
    send(8'h1C);
    chk("lit_after_to", 16'(data), 16'h01C);
    pop_one();

    do_reset();
    for (int c = 8'h15; c <= 8'h1D; c++) send(8'(c));
    chk("lit_ovf", 16'(overflow), 16'h1);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("lit_drain", 16'(data), 16'(10'h015 + k));
      pop_one();
    end
    @(negedge clk);
    chk("lit_drained", 16'(valid), 16'h0);

    do_reset();
    for (int c = 8'h30; c <= 8'h37; c++) send(8'(c));
    send_frame(8'h38, 1'b1, 11, -1, 1'b1);
    chk("lit_full_rdwr_ovf", 16'(overflow), 16'h0);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("lit_rdwr", 16'(data), 16'(10'h031 + k));
      pop_one();
    end
    @(negedge clk);
    chk("lit_rdwr_empty", 16'(valid), 16'h0);

    send_frame(8'h44, 1'b1, 4, -1, 1'b0);
    do_reset();
    send(8'h29);
    chk("lit_29", 16'(data), 16'h029);
    chk("lit_29_noerr", 16'(err_seen), 16'(exp_err));
    pop_one();

    send_frame(8'h5A, 1'b1, 11, 3, 1'b0);
    chk("lit_glitch", 16'(data), 16'h05A);
    pop_one();
    repeat (4) @(negedge clk);
    chk("final_err", 16'(err_seen), 16'(exp_err));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
